ddr_native_burst_arbiter: RTL and testbench

// Round-robin arbiter that shares one DDR native app interface (MIG UI) between two burst requesters, e.g. a VDMA write

---
 rtl/ddr_native_burst_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ddr_native_burst_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_native_burst_arbiter.sv
// Round-robin arbiter that multiplexes two burst requesters onto one MIG native app interface.
// Read returns are steered to their owner through a small in-order FIFO of {port, len}.
module ddr_native_burst_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_INC   = 8,
  parameter int ORD_DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0]                req_write_i,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [15:0]               req_len_i,
  input  logic [2*DATA_WIDTH-1:0]   wdata_i,
  input  logic [1:0]                wvalid_i,
  output logic [1:0]                wready_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic [1:0]                rvalid_o,
  output logic [1:0]                rlast_o,
  output logic [ADDR_WIDTH-1:0]     app_addr_o,
  output logic [2:0]                app_cmd_o,
  output logic                      app_en_o,
  input  logic                      app_rdy_i,
  output logic [DATA_WIDTH-1:0]     app_wdf_data_o,
  output logic                      app_wdf_wren_o,
  output logic                      app_wdf_end_o,
  output logic [DATA_WIDTH/8-1:0]   app_wdf_mask_o,
  input  logic                      app_wdf_rdy_i,
  input  logic [DATA_WIDTH-1:0]     app_rd_data_i,
  input  logic                      app_rd_data_valid_i,
  input  logic                      init_calib_complete_i
);

  localparam int PW = $clog2(ORD_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, WR_BURST, RD_BURST} state_e;

  state_e                state_q, state_d;
  logic                  rrPtr_q, rrPtr_d;
  logic                  gnt_q, gnt_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            cmdCnt_q, cmdCnt_d;
  logic [8:0]            datCnt_q, datCnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [8:0]            ordMem_q [ORD_DEPTH];
  logic [PW:0]           wrPtr_q, wrPtr_d;
  logic [PW:0]           rdPtr_q, rdPtr_d;
  logic [8:0]            rdBeat_q, rdBeat_d;

  logic [1:0]            eligible;
  logic                  sel, selWrite;
  logic [7:0]            selLen;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic                  cmdActive, dataActive, cmdFire, datFire;
  logic [8:0]            lenPlus;
  logic                  pushEn, ordFull, ordEmpty, beatValid, popEn;
  logic                  headPort;
  logic [7:0]            headLen;

  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    gnt_d       = gnt_q;
    len_d       = len_q;
    cmdCnt_d    = cmdCnt_q;
    datCnt_d    = datCnt_q;
    addr_d      = addr_q;
    req_ready_o = '0;
    wready_o    = '0;
    app_cmd_o   = 3'b111;
    pushEn      = 1'b0;

    // Reads are held off while the order FIFO cannot take another burst.
    eligible[0] = req_valid_i[0] && (req_write_i[0] || !ordFull);
    eligible[1] = req_valid_i[1] && (req_write_i[1] || !ordFull);
    sel         = (&eligible) ? ~rrPtr_q : ~eligible[0];
    selWrite    = sel ? req_write_i[1] : req_write_i[0];
    selLen      = sel ? req_len_i[15:8] : req_len_i[7:0];
    selAddr     = sel ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];

    cmdActive  = ((state_q == WR_BURST) || (state_q == RD_BURST)) && (cmdCnt_q <= {1'b0, len_q});
    dataActive = (state_q == WR_BURST) && (datCnt_q <= {1'b0, len_q});
    cmdFire    = cmdActive && app_rdy_i;
    datFire    = dataActive && app_wdf_rdy_i && (gnt_q ? wvalid_i[1] : wvalid_i[0]);
    lenPlus    = {1'b0, len_q} + 9'd1;

    if (dataActive && app_wdf_rdy_i) wready_o[gnt_q] = 1'b1;
    if (cmdFire) begin
      cmdCnt_d = cmdCnt_q + 9'd1;
      addr_d   = addr_q + ADDR_WIDTH'(ADDR_INC);
    end
    if (datFire) datCnt_d = datCnt_q + 9'd1;

    case (state_q)
      INIT: if (init_calib_complete_i) state_d = IDLE;
      IDLE: begin
        if (|eligible) begin
          req_ready_o[sel] = 1'b1;
          state_d  = selWrite ? WR_BURST : RD_BURST;
          rrPtr_d  = sel;
          gnt_d    = sel;
          len_d    = selLen;
          addr_d   = selAddr;
          cmdCnt_d = '0;
          datCnt_d = '0;
          pushEn   = !selWrite;
        end
      end
      WR_BURST: begin
        app_cmd_o = 3'b000;
        // Data may lead or lag the commands; leave only once both have completed.
        if ((cmdCnt_d == lenPlus) && (datCnt_d == lenPlus)) state_d = IDLE;
      end
      RD_BURST: begin
        app_cmd_o = 3'b001;
        if (cmdCnt_d == lenPlus) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    rdBeat_d  = rdBeat_q;
    rvalid_o  = '0;
    rlast_o   = '0;
    ordEmpty  = (wrPtr_q == rdPtr_q);
    ordFull   = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    headPort  = ordMem_q[rdPtr_q[PW-1:0]][8];
    headLen   = ordMem_q[rdPtr_q[PW-1:0]][7:0];
    // A return beat with nothing outstanding has no owner and is discarded.
    beatValid = app_rd_data_valid_i && !ordEmpty;
    popEn     = beatValid && (rdBeat_q == {1'b0, headLen});

    if (beatValid) begin
      rvalid_o[headPort] = 1'b1;
      rdBeat_d           = rdBeat_q + 9'd1;
    end
    if (popEn) begin
      rlast_o[headPort] = 1'b1;
      rdBeat_d          = '0;
      rdPtr_d           = rdPtr_q + 1'b1;
    end
    if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      rrPtr_q  <= 1'b1;
      gnt_q    <= 1'b0;
      len_q    <= '0;
      cmdCnt_q <= '0;
      datCnt_q <= '0;
      addr_q   <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      rdBeat_q <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      gnt_q    <= gnt_d;
      len_q    <= len_d;
      cmdCnt_q <= cmdCnt_d;
      datCnt_q <= datCnt_d;
      addr_q   <= addr_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      rdBeat_q <= rdBeat_d;
    end
  end

  always_ff @(posedge clock) begin
    if (pushEn) ordMem_q[wrPtr_q[PW-1:0]] <= {sel, selLen};
  end

  assign app_en_o       = cmdActive;
  assign app_addr_o     = addr_q;
  assign app_wdf_data_o = gnt_q ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
  assign app_wdf_wren_o = datFire;
  assign app_wdf_end_o  = 1'b1;
  assign app_wdf_mask_o = '0;
  assign rdata_o        = app_rd_data_i;

endmodule

// File: tb/tb_ddr_native_burst_arbiter.sv
// Scoreboard bench for ddr_native_burst_arbiter: a small MIG model plus per-port requesters,
// with expected commands, write beats and read beats queued at grant time and checked as they appear.
module tb_ddr_native_burst_arbiter;

  localparam int AW  = 27;
  localparam int DW  = 64;
  localparam int INC = 8;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } req_t;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } cmd_t;

  typedef struct packed {
    logic port;
    logic last;
  } rbeat_t;

  logic            clock = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_write, wvalid, wready, rvalid, rlast;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_len;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]   rdata, app_wdf_data, app_rd_data;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic            app_rd_data_valid, init_calib;
  logic [DW/8-1:0] app_wdf_mask;

  int testsRun = 0;
  int testsFailed = 0;

  req_t          reqQ0[$], reqQ1[$];
  logic [DW-1:0] wdQ0[$], wdQ1[$], wExpQ[$], migRdQ[$];
  cmd_t          cmdExpQ[$];
  rbeat_t        rdExpQ[$];
  bit            grantLog[$];
  logic [3:0]    rdLog[$];

  bit            lastGrant = 1'b1;
  int            modelRdCount = 0;
  int            wrenCount = 0;
  bit            rdyRandom = 1'b0;
  bit            returnEn = 1'b1;

  logic [1:0]    eligM, expReady;
  logic          gp;
  req_t          r;
  cmd_t          c;
  rbeat_t        rb;
  logic [DW-1:0] d;

  ddr_native_burst_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_INC(INC), .ORD_DEPTH(4)
  ) dut (
    .clock(clock), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready),
    .rdata_o(rdata), .rvalid_o(rvalid), .rlast_o(rlast),
    .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
    .app_wdf_data_o(app_wdf_data), .app_wdf_wren_o(app_wdf_wren), .app_wdf_end_o(app_wdf_end),
    .app_wdf_mask_o(app_wdf_mask), .app_wdf_rdy_i(app_wdf_rdy),
    .app_rd_data_i(app_rd_data), .app_rd_data_valid_i(app_rd_data_valid),
    .init_calib_complete_i(init_calib)
  );

  initial forever #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input int write, input int addr, input int len);
    req_t q;
    q.write = (write != 0);
    q.addr  = AW'(addr);
    q.len   = 8'(len);
    if (port == 0) reqQ0.push_back(q);
    else           reqQ1.push_back(q);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 2'b00);
    checkOutput({tag, "_wready"}, wready, 2'b00);
    checkOutput({tag, "_rvalid"}, rvalid, 2'b00);
    checkOutput({tag, "_rlast"}, rlast, 2'b00);
    checkOutput({tag, "_app_en"}, app_en, 1'b0);
    checkOutput({tag, "_app_cmd"}, app_cmd, 3'b111);
    checkOutput({tag, "_app_addr"}, app_addr, '0);
  endtask

  task automatic waitDrain(input string tag, input int maxCycles);
    int n = 0;
    while ((cmdExpQ.size() + wExpQ.size() + rdExpQ.size() + reqQ0.size() + reqQ1.size()
            + wdQ0.size() + wdQ1.size()) != 0 && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, n >= maxCycles, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic waitGranted(input string tag, input int maxCycles);
    int n = 0;
    while ((reqQ0.size() + reqQ1.size()) != 0 && n < maxCycles) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, n >= maxCycles, 0);
  endtask

  // Requesters, write-data sources and the MIG model all change on the rising edge plus 1.
  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    wvalid = '0; wdata = '0; app_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
    forever begin
      @(posedge clock);
      #1;
      req_valid[0] = reqQ0.size() != 0;
      if (reqQ0.size() != 0) begin
        req_write[0] = reqQ0[0].write; req_addr[AW-1:0] = reqQ0[0].addr; req_len[7:0] = reqQ0[0].len;
      end
      req_valid[1] = reqQ1.size() != 0;
      if (reqQ1.size() != 0) begin
        req_write[1] = reqQ1[0].write; req_addr[2*AW-1:AW] = reqQ1[0].addr; req_len[15:8] = reqQ1[0].len;
      end
      wvalid[0] = wdQ0.size() != 0;
      if (wdQ0.size() != 0) wdata[DW-1:0] = wdQ0[0];
      wvalid[1] = wdQ1.size() != 0;
      if (wdQ1.size() != 0) wdata[2*DW-1:DW] = wdQ1[0];
      app_rdy = rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      if (returnEn && migRdQ.size() != 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = migRdQ.pop_front();
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  // Monitor: grant arbitration model, command/write/read scoreboards.
  always @(negedge clock) begin
    if (!rst) begin
      if (req_ready != 2'b00) begin
        eligM[0] = req_valid[0] && (req_write[0] || modelRdCount < 4);
        eligM[1] = req_valid[1] && (req_write[1] || modelRdCount < 4);
        if (eligM == 2'b00)      expReady = 2'b00;
        else if (eligM == 2'b11) expReady = lastGrant ? 2'b01 : 2'b10;
        else                     expReady = eligM;
        checkOutput("grant", req_ready, expReady);
        gp = req_ready[1];
        lastGrant = gp;
        grantLog.push_back(gp);
        if (gp ? reqQ1.size() == 0 : reqQ0.size() == 0) begin
          checkOutput("grant_no_req", 1, 0);
        end else begin
          r = gp ? reqQ1.pop_front() : reqQ0.pop_front();
          for (int i = 0; i <= int'(r.len); i++) begin
            c.cmd  = r.write ? 3'd0 : 3'd1;
            c.addr = r.addr + AW'(i * INC);
            cmdExpQ.push_back(c);
            if (r.write) begin
              d = {$urandom, $urandom};
              if (gp) wdQ1.push_back(d); else wdQ0.push_back(d);
              wExpQ.push_back(d);
            end else begin
              rb.port = gp;
              rb.last = (i == int'(r.len));
              rdExpQ.push_back(rb);
            end
          end
          if (!r.write) modelRdCount++;
        end
      end

      if (app_en && app_rdy) begin
        if (cmdExpQ.size() == 0) begin
          checkOutput("cmd_extra", 1, 0);
        end else begin
          c = cmdExpQ.pop_front();
          checkOutput("cmd", app_cmd, c.cmd);
          checkOutput("cmd_addr", app_addr, c.addr);
          if (c.cmd == 3'd1) migRdQ.push_back({$urandom, $urandom});
        end
      end

      if (wready != 2'b00) checkOutput("wready_port", wready, 2'b01 << lastGrant);
      if (app_wdf_wren || (wvalid & wready) != 2'b00)
        checkOutput("wren", app_wdf_wren, (wvalid & wready) != 2'b00);
      if (app_wdf_wren) begin
        wrenCount++;
        if (wExpQ.size() == 0) checkOutput("wdata_extra", 1, 0);
        else                   checkOutput("wdata", app_wdf_data, wExpQ.pop_front());
        checkOutput("wdf_end_mask", {app_wdf_end, app_wdf_mask}, {1'b1, 8'h00});
      end
      if (wvalid[0] && wready[0] && wdQ0.size() != 0) void'(wdQ0.pop_front());
      if (wvalid[1] && wready[1] && wdQ1.size() != 0) void'(wdQ1.pop_front());

      if (app_rd_data_valid) begin
        rdLog.push_back({rvalid, rlast});
        if (rdExpQ.size() == 0) begin
          checkOutput("rd_orphan", 1, 0);
        end else begin
          rb = rdExpQ.pop_front();
          checkOutput("rvalid", rvalid, 2'b01 << rb.port);
          checkOutput("rlast", rlast, rb.last ? (2'b01 << rb.port) : 2'b00);
          checkOutput("rdata", rdata, app_rd_data);
          if (rb.last) modelRdCount--;
        end
      end else if (rvalid != 2'b00 || rlast != 2'b00) begin
        checkOutput("rvalid_idle", {rvalid, rlast}, 4'b0000);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readyCount, base, repeats;
    rst = 1'b1; init_calib = 1'b0; app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetValues("reset");
    @(posedge clock); #1;
    rst = 1'b0;

    // Calibration gate and first-accept latency.
    applyStimulus(0, 1, 'h100, 3);
    readyCount = 0;
    repeat (20) begin
      @(negedge clock);
      if (req_ready != 2'b00) readyCount++;
    end
    checkOutput("ready_before_calib", readyCount, 0);
    @(posedge clock); #1;
    init_calib = 1'b1;
    @(negedge clock); checkOutput("ready_calib_edge", req_ready, 2'b00);
    @(negedge clock); checkOutput("ready_after_calib", req_ready, 2'b01);
    @(negedge clock);
    checkOutput("app_en_first", app_en, 1'b1);
    checkOutput("app_addr_first", app_addr, 'h100);
    base = wrenCount;
    waitDrain("drain_first_write", 200);
    checkOutput("first_write_wren", wrenCount - base, 4);
    checkOutput("idle_cmd", app_cmd, 3'b111);

    // Both ports always requesting: grants must alternate.
    base = grantLog.size();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 'h1000 + i * 'h40, 1);
      applyStimulus(1, 1, 'h2000 + i * 'h40, 1);
    end
    waitDrain("drain_alternate", 500);
    repeats = 0;
    for (int i = base + 1; i < grantLog.size(); i++)
      if (grantLog[i] == grantLog[i-1]) repeats++;
    checkOutput("alt_grant_count", grantLog.size() - base, 6);
    checkOutput("alt_repeats", repeats, 0);
    checkOutput("alt_first_port", grantLog[base], 1);

    // In-order read return demux.
    base = rdLog.size();
    applyStimulus(1, 0, 'h3000, 1);
    waitGranted("rd_port1_granted", 50);
    applyStimulus(0, 0, 'h4000, 0);
    waitDrain("drain_reads", 200);
    checkOutput("rd_beat_count", rdLog.size() - base, 3);
    checkOutput("rd_beat0", rdLog[base], 4'b1000);
    checkOutput("rd_beat1", rdLog[base+1], 4'b1010);
    checkOutput("rd_beat2", rdLog[base+2], 4'b0101);

    // Order FIFO full: a fifth read waits while a write goes through.
    returnEn = 1'b0;
    applyStimulus(0, 0, 'h5000, 0);
    applyStimulus(1, 0, 'h5100, 0);
    applyStimulus(0, 0, 'h5200, 0);
    applyStimulus(1, 0, 'h5300, 0);
    waitGranted("four_reads_granted", 100);
    applyStimulus(1, 0, 'h5400, 0);
    applyStimulus(0, 1, 'h6000, 2);
    repeat (30) @(negedge clock);
    checkOutput("fifth_read_blocked", reqQ1.size(), 1);
    checkOutput("write_while_full", reqQ0.size(), 0);
    returnEn = 1'b1;
    waitDrain("drain_full", 300);

    // Command backpressure and stalled write FIFO.
    rdyRandom = 1'b1;
    @(posedge clock); #1;
    app_wdf_rdy = 1'b0;
    base = wrenCount;
    applyStimulus(0, 1, 'h7000, 7);
    applyStimulus(1, 0, 'h8000, 5);
    repeat (10) @(posedge clock);
    #1;
    app_wdf_rdy = 1'b1;
    waitDrain("drain_stress", 500);
    checkOutput("stress_wren", wrenCount - base, 8);

    // Address wrap and the longest burst.
    base = rdLog.size();
    applyStimulus(0, 1, 'h7FF_FFF8, 1);
    applyStimulus(1, 0, 'h10, 255);
    waitDrain("drain_boundary", 2000);
    checkOutput("long_read_beats", rdLog.size() - base, 256);

    // Reset in the middle of a write burst.
    rdyRandom = 1'b0;
    applyStimulus(1, 1, 'h9000, 15);
    waitGranted("midburst_granted", 50);
    repeat (4) @(negedge clock);
    @(posedge clock); #2;
    rst = 1'b1;
    reqQ0.delete(); reqQ1.delete(); wdQ0.delete(); wdQ1.delete();
    wExpQ.delete(); cmdExpQ.delete(); rdExpQ.delete(); migRdQ.delete();
    modelRdCount = 0;
    lastGrant = 1'b1;
    @(negedge clock);
    checkResetValues("midburst");
    checkOutput("midburst_wren", app_wdf_wren, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;

    // Round-robin pointer is back to its reset value: port 0 wins the tie.
    base = grantLog.size();
    applyStimulus(0, 1, 'hA000, 0);
    applyStimulus(1, 1, 'hB000, 0);
    waitDrain("drain_post_reset", 200);
    checkOutput("post_reset_first_grant", grantLog[base], 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
